lcd_host: RTL and testbench

LCD_HOST -- requirements
Module: lcd_host

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_iram_monitor.sv | 40 ++++
 rtl/lcd_host.sv | 137 +++++++++++++
 tb/tb_lcd_host.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared encodings for the LCD host: controller commands, host FSM states,
// error codes and the image size the controller writes back.
package lcd_pkg;
   localparam int IMG_PIXELS = 64;

   typedef enum logic [3:0] {
      CMD_WRITE      = 4'd0,
      CMD_SHIFT_UP   = 4'd1,
      CMD_SHIFT_DOWN = 4'd2,
      CMD_SHIFT_LEFT = 4'd3,
      CMD_SHIFT_RIGHT= 4'd4,
      CMD_MAX        = 4'd5,
      CMD_MIN        = 4'd6,
      CMD_AVERAGE    = 4'd7,
      CMD_ROT_CCW    = 4'd8,
      CMD_ROT_CW     = 4'd9,
      CMD_MIRROR_X   = 4'd10,
      CMD_MIRROR_Y   = 4'd11
   } cmd_e;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_GAP, S_DRAIN, S_DONE, S_ERR
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_ORDER   = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_EARLY   = 2'd3
   } err_e;
endpackage

// File: rtl/lcd_iram_monitor.sv
// Watches controller write-back during DRAIN: enforces in-order addresses,
// counts accepted writes and accumulates the written pixel values.
module lcd_iram_monitor
   import lcd_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic        i_valid,
   input  logic [5:0]  i_addr,
   input  logic [7:0]  i_data,
   output logic [6:0]  o_wr_cnt,
   output logic [13:0] o_img_sum,
   output logic        o_accept,
   output logic        o_bad,
   output logic [6:0]  o_cnt_next
);
   logic [6:0]  r_wr_cnt;
   logic [13:0] r_img_sum;
   logic        w_hit;

   // A write past the last pixel can never match, so it is flagged out of order.
   assign w_hit      = i_valid && (r_wr_cnt < 7'(IMG_PIXELS)) && (i_addr == r_wr_cnt[5:0]);
   assign o_accept   = i_en && w_hit;
   assign o_bad      = i_en && i_valid && !w_hit;
   assign o_cnt_next = r_wr_cnt + {6'd0, o_accept};
   assign o_wr_cnt   = r_wr_cnt;
   assign o_img_sum  = r_img_sum;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_wr_cnt  <= '0;
         r_img_sum <= '0;
      end else if (o_accept) begin
         r_wr_cnt  <= r_wr_cnt + 7'd1;
         r_img_sum <= r_img_sum + {6'd0, i_data};
      end
   end
endmodule

// File: rtl/lcd_host.sv
// Command sequencer for an LCD image controller: walks command memory, issues
// one command per handshake and supervises the write-back of the image.
module lcd_host
   import lcd_pkg::*;
#(
   parameter int CMD_AW  = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [CMD_AW-1:0] CMD_A,
   input  logic [3:0]        CMD_Q,
   output logic [3:0]        cmd,
   output logic              cmd_valid,
   input  logic              busy,
   input  logic              IRAM_valid,
   input  logic [5:0]        IRAM_A,
   input  logic [7:0]        IRAM_D,
   input  logic              done,
   output logic [6:0]        wr_cnt,
   output logic [13:0]       img_sum,
   output logic              finish,
   output logic [1:0]        err
);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_e            r_state;
   logic [CMD_AW-1:0] r_cmd_a;
   logic [3:0]        r_cmd;
   logic              r_cmd_valid;
   logic              r_finish;
   err_e              r_err;
   logic [TW-1:0]     r_timer;

   logic       w_start_ok;
   logic       w_accept;
   logic       w_bad;
   logic [6:0] w_cnt_next;

   assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);

   lcd_iram_monitor u_mon (
      .clk        (clk),
      .reset      (reset),
      .i_clr      (w_start_ok),
      .i_en       (r_state == S_DRAIN),
      .i_valid    (IRAM_valid),
      .i_addr     (IRAM_A),
      .i_data     (IRAM_D),
      .o_wr_cnt   (wr_cnt),
      .o_img_sum  (img_sum),
      .o_accept   (w_accept),
      .o_bad      (w_bad),
      .o_cnt_next (w_cnt_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cmd_a     <= '0;
         r_cmd       <= '0;
         r_cmd_valid <= 1'b0;
         r_finish    <= 1'b0;
         r_err       <= ERR_NONE;
         r_timer     <= '0;
      end else begin
         r_cmd_valid <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (w_start_ok) begin
                  r_state  <= S_FETCH;
                  r_cmd_a  <= '0;
                  r_finish <= 1'b0;
                  r_err    <= ERR_NONE;
                  r_timer  <= '0;
               end
            end
            S_FETCH: begin
               r_cmd   <= CMD_Q;
               r_timer <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (!busy) begin
                  r_cmd_valid <= 1'b1;
                  r_state     <= S_ISSUE;
               end else if (r_timer == TW'(TIMEOUT - 1)) begin
                  r_err   <= ERR_TIMEOUT;
                  r_state <= S_ERR;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_ISSUE: r_state <= S_GAP;
            S_GAP: begin
               if (r_cmd == CMD_WRITE) begin
                  r_timer <= '0;
                  r_state <= S_DRAIN;
               end else begin
                  r_cmd_a <= r_cmd_a + 1'b1;
                  r_state <= S_FETCH;
               end
            end
            S_DRAIN: begin
               // The done check sees the count including a write landing in the same cycle.
               if (w_bad) begin
                  r_err   <= ERR_ORDER;
                  r_state <= S_ERR;
               end else if (done) begin
                  if (w_cnt_next == 7'(IMG_PIXELS)) begin
                     r_finish <= 1'b1;
                     r_state  <= S_DONE;
                  end else begin
                     r_err   <= ERR_EARLY;
                     r_state <= S_ERR;
                  end
               end else if (w_accept) begin
                  r_timer <= '0;
               end else if (r_timer == TW'(TIMEOUT - 1)) begin
                  r_err   <= ERR_TIMEOUT;
                  r_state <= S_ERR;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign CMD_A     = r_cmd_a;
   assign cmd       = r_cmd;
   assign cmd_valid = r_cmd_valid;
   assign finish    = r_finish;
   assign err       = r_err;
endmodule

// File: tb/tb_lcd_host.sv
// Directed-plus-random bench for lcd_host: a small controller model answers
// commands and writes the image back, expectations come from plain arithmetic.
module tb_lcd_host;
   localparam int AW = 8;
   localparam int TO = 1023;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] CMD_A;
   logic [3:0]    CMD_Q;
   logic [3:0]    cmd;
   logic          cmd_valid;
   logic          busy = 1'b0;
   logic          IRAM_valid = 1'b0;
   logic [5:0]    IRAM_A = '0;
   logic [7:0]    IRAM_D = '0;
   logic          done = 1'b0;
   logic [6:0]    wr_cnt;
   logic [13:0]   img_sum;
   logic          finish;
   logic [1:0]    err;

   logic [3:0] mem [0:(1<<AW)-1];
   logic [3:0] got_q [$];
   logic [3:0] exp_q [$];
   int         checks = 0;
   int         failures = 0;
   int         exp_cnt = 0;
   int         exp_sum = 0;
   logic       busy_force = 1'b0;
   int         bcnt = 0;
   logic       prev_cv = 1'b0;

   lcd_host #(.CMD_AW(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .CMD_A(CMD_A), .CMD_Q(CMD_Q),
      .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .IRAM_valid(IRAM_valid),
      .IRAM_A(IRAM_A), .IRAM_D(IRAM_D), .done(done), .wr_cnt(wr_cnt),
      .img_sum(img_sum), .finish(finish), .err(err)
   );

   assign CMD_Q = mem[CMD_A];
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Controller busy: registered, rises after each command for 1..4 cycles.
   always @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
         bcnt <= 0;
      end else if (busy_force) begin
         busy <= 1'b1;
      end else if (cmd_valid) begin
         busy <= 1'b1;
         bcnt <= $urandom_range(0, 3);
      end else if (bcnt != 0) begin
         bcnt <= bcnt - 1;
      end else begin
         busy <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (cmd_valid) begin
         chk("cv_while_busy", busy, 1'b0);
         chk("cv_back_to_back", prev_cv, 1'b0);
         got_q.push_back(cmd);
      end
      prev_cv = cmd_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_start;
      got_q.delete();
      exp_cnt = 0;
      exp_sum = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_cmd0(input int budget);
      int n = 0;
      while (!(cmd_valid === 1'b1 && cmd === 4'd0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("write_cmd_seen", 32'(n < budget), 1);
   endtask

   // A stray write during GAP must be ignored; the next cycle is DRAIN.
   task automatic enter_drain;
      @(negedge clk);
      IRAM_valid = 1'b1;
      IRAM_A = 6'd0;
      IRAM_D = 8'hFF;
      @(negedge clk);
      IRAM_valid = 1'b0;
   endtask

   task automatic writes(input int n, input bit rnd, input bit done_last);
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(0, 3) == 0) begin
            IRAM_valid = 1'b0;
            @(negedge clk);
         end
         IRAM_valid = 1'b1;
         IRAM_A = 6'(exp_cnt);
         IRAM_D = rnd ? 8'($urandom_range(0, 255)) : 8'(exp_cnt);
         done = done_last && (i == n - 1);
         exp_sum += int'(IRAM_D);
         exp_cnt++;
         @(negedge clk);
      end
      IRAM_valid = 1'b0;
      done = 1'b0;
   endtask

   task automatic pulse_done;
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
   endtask

   task automatic chk_seq(input string tag);
      chk({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [3:0] o;
         o = (i < got_q.size()) ? got_q[i] : 4'bx;
         chk(tag, 32'(o), 32'(exp_q[i]));
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 4'hF;
      mem[0] = 4'd4; mem[1] = 4'd2; mem[2] = 4'd7; mem[3] = 4'd0;
      exp_q = '{4'd4, 4'd2, 4'd7, 4'd0};

      tick(3);
      chk("rst_CMD_A", 32'(CMD_A), 0);
      chk("rst_cmd", cmd, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_wr_cnt", wr_cnt, 0);
      chk("rst_img_sum", img_sum, 0);
      chk("rst_finish", finish, 0);
      chk("rst_err", err, 0);
      reset = 1'b0;
      IRAM_valid = 1'b1;
      tick(3);
      IRAM_valid = 1'b0;
      chk("idle_no_cmd", got_q.size(), 0);
      chk("idle_write_ignored", wr_cnt, 0);

      // Basic run: busy high for 5 cycles, image 0..63, done on its own cycle.
      busy_force = 1'b1;
      run_start;
      tick(4);
      busy_force = 1'b0;
      wait_cmd0(200);
      enter_drain;
      chk_seq("seq_basic");
      writes(64, 1'b0, 1'b0);
      chk("basic_pre_done_finish", finish, 0);
      chk("basic_pre_done_cnt", wr_cnt, 64);
      pulse_done;
      chk("basic_finish", finish, 1);
      chk("basic_err", err, 0);
      chk("basic_wr_cnt", wr_cnt, 64);
      chk("basic_sum", img_sum, 2016);
      chk("basic_sum_model", img_sum, 32'(exp_sum));
      tick(5);
      chk("done_sticky", finish, 1);
      chk("done_no_more_cmd", got_q.size(), 4);

      // Out-of-order address after 4 writes.
      run_start;
      wait_cmd0(200);
      enter_drain;
      chk_seq("seq_order");
      writes(4, 1'b1, 1'b0);
      IRAM_valid = 1'b1;
      IRAM_A = 6'd5;
      IRAM_D = 8'h11;
      tick(1);
      chk("order_err", err, 1);
      chk("order_finish", finish, 0);
      chk("order_cnt", wr_cnt, 4);
      IRAM_A = 6'd4;
      tick(2);
      IRAM_valid = 1'b0;
      chk("order_frozen_cnt", wr_cnt, 4);
      chk("order_frozen_sum", img_sum, 32'(exp_sum));
      chk("order_err_sticky", err, 1);

      // Done after only 10 writes.
      run_start;
      chk("restart_clears_err", err, 0);
      wait_cmd0(200);
      enter_drain;
      writes(10, 1'b1, 1'b0);
      pulse_done;
      chk("early_err", err, 3);
      chk("early_cnt", wr_cnt, 10);
      chk("early_finish", finish, 0);

      // Last write coincides with done.
      run_start;
      wait_cmd0(200);
      enter_drain;
      writes(64, 1'b1, 1'b1);
      chk("coinc_finish", finish, 1);
      chk("coinc_err", err, 0);
      chk("coinc_cnt", wr_cnt, 64);
      chk("coinc_sum", img_sum, 32'(exp_sum));

      // DRAIN timeout; the timer restarts after each accepted write.
      run_start;
      wait_cmd0(200);
      enter_drain;
      writes(3, 1'b1, 1'b0);
      tick(TO - 1);
      chk("drain_to_early", err, 0);
      tick(1);
      chk("drain_to_err", err, 2);
      chk("drain_to_cnt", wr_cnt, 3);

      // WAIT timeout with busy stuck high.
      busy_force = 1'b1;
      run_start;
      tick(TO);
      chk("wait_to_early", err, 0);
      tick(1);
      chk("wait_to_err", err, 2);
      chk("wait_to_no_cmd", got_q.size(), 0);
      busy_force = 1'b0;

      // Reset in DRAIN after 20 writes, reset beats start, then a clean rerun.
      run_start;
      wait_cmd0(200);
      enter_drain;
      writes(20, 1'b1, 1'b0);
      reset = 1'b1;
      tick(1);
      chk("midrst_cnt", wr_cnt, 0);
      chk("midrst_sum", img_sum, 0);
      chk("midrst_cv", cmd_valid, 0);
      chk("midrst_CMD_A", 32'(CMD_A), 0);
      chk("midrst_err", err, 0);
      start = 1'b1;
      tick(1);
      reset = 1'b0;
      start = 1'b0;
      tick(8);
      chk("rst_beats_start", got_q.size(), 4);
      run_start;
      wait_cmd0(200);
      enter_drain;
      chk_seq("seq_rerun");
      writes(64, 1'b1, 1'b1);
      chk("rerun_finish", finish, 1);
      chk("rerun_cnt", wr_cnt, 64);
      chk("rerun_sum", img_sum, 32'(exp_sum));

      // Random non-write commands over the whole memory, wrapping back to 0.
      for (int i = 0; i < (1 << AW); i++) mem[i] = 4'($urandom_range(1, 15));
      exp_q.delete();
      for (int i = 0; i < (1 << AW); i++) exp_q.push_back(mem[i]);
      exp_q.push_back(mem[0]);
      exp_q.push_back(4'd0);
      run_start;
      n = 0;
      while (got_q.size() < 100 && n < 2000) begin
         tick(1);
         n++;
      end
      mem[1] = 4'd0;
      wait_cmd0(4000);
      tick(1);
      chk_seq("seq_wrap");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
